multicycle_alu: RTL

Parametrised, clocked successor to the 4-bit combinational ALU. Same 3-bit opcode set, generalised to `W`-bit operands, with registered results, valid/ready handshakes and an iterative shift-add multiplier. Sits between the operand-issue logic and the result writeback stage. Holds at most one operation in flight.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_mul_seq.sv | 50 +++++
 rtl/multicycle_alu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and single-cycle result function for multicycle_alu.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_RSUB = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_SHR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    // Widest W supported; callers zero-extend operands and truncate the result.
    localparam int MAX_W = 32;
    localparam int EXT_W = MAX_W + 1;

    // Extended result R for every opcode except MUL (returns 0 for MUL).
    function automatic logic [EXT_W-1:0] alu_ext(input logic [2:0] op,
                                                 input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input logic xin,
                                                 input int w);
        logic [EXT_W-1:0] ae, be, xe, mask_w1, mask_w, r;
        ae      = {1'b0, a};
        be      = {1'b0, b};
        xe      = EXT_W'(xin);
        mask_w1 = ~({EXT_W{1'b1}} << (w + 1));
        mask_w  = ~({EXT_W{1'b1}} << w);
        case (op)
            OP_ADD:  r = ae + be + xe;
            OP_RSUB: r = (be + xe - ae) & mask_w1;
            OP_SUB:  r = (ae + xe - be) & mask_w1;
            OP_SHL:  r = ae << 1;
            OP_SHR:  r = ae >> 1;
            OP_XOR:  r = ae ^ be;
            OP_SLT:  r = (a < b) ? mask_w : '0;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative W x W shift-add multiplier: one multiplier bit per cycle, product held after done.
module alu_mul_seq #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= {{W{1'b0}}, a};
                mplier  <= b;
                product <= '0;
                cnt     <= '0;
                busy    <= 1'b1;
            end else if (busy) begin
                if (mplier[0])
                    product <= product + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == CW'(W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Clocked W-bit ALU with valid/ready handshakes; MUL is iterative when MULTICYCLE_ALU_MUL_EN
// is defined, otherwise opcode 101 is a single-cycle op yielding zero.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic         XIN,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [2:0]   S,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] F,
    output logic [W-1:0] FH,
    output logic         Z,
    output logic         V,
    output logic         C
);
    state_t       state, state_nx;
    logic         slot_free, accept, load;
    logic [W:0]   r1;
    logic [W-1:0] f_nx;
    logic         z_nx, v_nx, c_nx;

    assign slot_free = !OUT_VALID || OUT_READY;
    assign IN_READY  = !RST && (state == ST_IDLE) && slot_free;
    assign accept    = IN_VALID && IN_READY;
    assign r1        = (W+1)'(alu_ext(S, MAX_W'(A), MAX_W'(B), XIN, W));

`ifdef MULTICYCLE_ALU_MUL_EN
    logic           mul_busy, mul_done, mul_wait, mul_avail;
    logic [2*W-1:0] mul_p;
    logic [W-1:0]   fh_nx;

    alu_mul_seq #(.W(W)) u_mul (
        .clk     (CLK),
        .rst     (RST),
        .start   (accept && (S == OP_MUL)),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_p)
    );

    // Remembers a finished product while the output slot is still occupied.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            mul_wait <= 1'b0;
        else if (load)
            mul_wait <= 1'b0;
        else if (mul_done)
            mul_wait <= 1'b1;
    end

    assign mul_avail = (mul_done || mul_wait) && !mul_busy;
`endif

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        f_nx     = r1[W-1:0];
        z_nx     = ~|r1;
        v_nx     = r1[W];
        c_nx     = ((S == OP_ADD) || (S == OP_RSUB) || (S == OP_SUB)) && r1[W];
`ifdef MULTICYCLE_ALU_MUL_EN
        fh_nx    = '0;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef MULTICYCLE_ALU_MUL_EN
                    if (S == OP_MUL)
                        state_nx = ST_MUL;
                    else
                        load = 1'b1;
`else
                    load = 1'b1;
`endif
                end
            end
`ifdef MULTICYCLE_ALU_MUL_EN
            ST_MUL: begin
                f_nx  = mul_p[W-1:0];
                fh_nx = mul_p[2*W-1:W];
                z_nx  = ~|mul_p;
                v_nx  = |mul_p[2*W-1:W];
                c_nx  = 1'b0;
                if (mul_avail && slot_free) begin
                    load     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            OUT_VALID <= 1'b0;
            F         <= '0;
            Z         <= 1'b0;
            V         <= 1'b0;
            C         <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                OUT_VALID <= 1'b1;
                F         <= f_nx;
                Z         <= z_nx;
                V         <= v_nx;
                C         <= c_nx;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

`ifdef MULTICYCLE_ALU_MUL_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            FH <= '0;
        else if (load)
            FH <= fh_nx;
    end
`else
    assign FH = '0;
`endif

endmodule
